conv_tile_ctrl: RTL
===================

# conv_tile_ctrl

Sequencer for the Tn-lane MAC/reduction datapath (input_loop). Walks the convolution loop nest for one layer tile: output channel, output row, output column, input-channel group of Tn_p lanes, kernel row, kernel column. Each step is emitted as one "beat" carrying loop indices, a lane-valid mask and first/last flags. Buffer address generators and the accumulator/write-back stage downstream consume the beat: `first_o` selects fm_init = 0, and `last_o` commits fm_o. The controller owns no arithmetic on feature-map data; it only sequences.

## Interface

**Parameters**
- `Tn_p`, 1, number of parallel input-channel lanes in the MAC datapath.
- `DIM_W_p`, 8, width of every dimension input and loop index.

**Ports**
- `clk_i` in 1: the single clock.
- `reset_n_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: start a layer tile; sampled only in IDLE.
- `n_i`, `m_i`, `r_i`, `c_i`, `k_i` in DIM_W_p each: input channels, output channels, output rows, output cols, kernel size. Latched on accepted start.
- `busy_o` out 1: high while in RUN.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: with `done_o`, indicates the latched config had a zero dimension.
- `beat_v_o` out 1: beat valid.
- `beat_ready_i` in 1: consumer accepts the beat.
- `och_o`, `row_o`, `col_o`, `ch_base_o`, `kr_o`, `kc_o` out DIM_W_p each: current beat indices.
- `lane_mask_o` out Tn_p: bit l = 1 iff `ch_base_o` + l < n.
- `first_o` out 1: first beat of an output pixel.
- `last_o` out 1: last beat of an output pixel.

## Operation

**States**
- **IDLE**
  - Accepted `start_i` latches the config.
  - If any of n, m, r, c, k is zero, go to DONE with err set.
  - Otherwise go to RUN with all indices 0.
- **RUN**
  - `beat_v_o` = 1.
  - On `beat_v_o` && `beat_ready_i`:
    - If it was the final beat, go to DONE.
    - Otherwise advance the counters.
- **DONE**
  - `done_o` = 1, and `err_o` = latched err.
  - Next cycle: IDLE, and err is cleared.

**Counter advance** (odometer, innermost first)
- kc 0..k-1
- kr 0..k-1
- ch_base 0, Tn_p, 2·Tn_p, … while ch_base < n
- col 0..c-1
- row 0..r-1
- och 0..m-1
- Each counter wraps to 0 and carries into the next.
- Final beat: every counter is at its last value.

**Flags**
- `first_o` = (ch_base == 0 && kr == 0 && kc == 0).
- `last_o` = (ch_base + Tn_p ≥ n && kr == k-1 && kc == k-1).
- Both are 1 on the same beat when n ≤ Tn_p and k = 1.

**Width rules**
- ch_base + Tn_p and the lane comparisons are evaluated in DIM_W_p+1 bits, so there is no wrap for n near 2^DIM_W_p.
- Total beats = m·r·c·ceil(n/Tn_p)·k².

**Handshake**
- While `beat_v_o` = 1 and `beat_ready_i` = 0, all beat outputs hold stable.
- `beat_v_o` never drops without a handshake, except on reset.

**Boundary conditions**
- `start_i` in RUN or DONE is ignored; it is not queued.
- Config inputs changing during RUN have no effect.
- `beat_ready_i` high in IDLE or DONE has no effect.
- `lane_mask_o` is all ones except on the last channel group, where it is partial when n mod Tn_p ≠ 0.
- Reset asserted mid-RUN: next edge goes to IDLE, and no `done_o` is issued.

**Reset values**
- All outputs are 0: `busy_o`, `done_o`, `err_o`, `beat_v_o`, all indices, `lane_mask_o`, `first_o`, `last_o`.
- State is IDLE.

## Timing

- All outputs are registered or decoded directly from registered state; there is no combinational path from `beat_ready_i` to outputs.
- Start accepted at edge t:
  - `busy_o` = 1 and the first beat is valid in cycle t+1.
- Final handshake at edge u:
  - `beat_v_o` = 0, `busy_o` = 0 and `done_o` = 1 in cycle u+1.
  - IDLE in cycle u+2.
  - A new `start_i` is accepted in cycle u+2 or later.
- Zero config accepted at edge t: `done_o` = `err_o` = 1 in cycle t+1, and `busy_o` stays 0.
- With `beat_ready_i` tied high, `done_o` asserts at cycle t+1+B, where B = total beats.
- Throughput: one beat per cycle.

## Test plan

- **Partial lane group:** Tn_p=2, n=3, m=r=c=k=1, ready high.
  - Beat 0: ch_base 0, mask 11, first=1, last=0.
  - Beat 1: ch_base 2, mask 01, first=0, last=1.
  - `done_o` at t+3.
- **Full nest order:** Tn_p=2, n=2, m=2, r=1, c=2, k=2, ready high.
  - 16 beats; kc fastest, then kr, col, och.
  - first on beats 0, 4, 8, 12; last on beats 3, 7, 11, 15.
  - `done_o` at t+17.
- **Backpressure:** the nest-order config with `beat_ready_i` random at 50%.
  - Payload stable during every stall.
  - Beat sequence identical to the ready-high run.
  - `done_o` exactly one cycle after the 16th handshake.
- **Zero config:** k=0, start.
  - `done_o` = `err_o` = 1 next cycle.
  - No `beat_v_o`, and `busy_o` stays 0.
  - Next start with valid config runs normally, with `err_o` = 0.
- **Reset mid-run:** drop `reset_n_i` for 1 cycle after beat 5 of the full nest.
  - All outputs 0 the next cycle, and no `done_o`.
  - Restart produces the full 16-beat sequence from beat 0.
- **Ignored start / width edge:** pulse `start_i` during RUN and during DONE, and use n=255 with Tn_p=4 and DIM_W_p=8.
  - Single `done_o` only.
  - Last group ch_base=252, mask 0111, no index wrap.

Source files
------------

// File: rtl/conv_tile_ctrl.sv
// conv_tile_ctrl
//
// Sequencer for the Tn-lane MAC/reduction datapath. For one layer tile it walks
// the convolution loop nest and emits one beat per step. The nest, outermost
// first, is: output channel, output row, output column, input-channel group of
// Tn_p lanes, kernel row, kernel column. The block does no arithmetic on
// feature-map data; it only produces indices, a lane mask and first/last flags.
//
// Ports
//   clk_i, reset_n_i     clock and synchronous active-low reset
//   start_i              start a tile; only looked at while idle
//   n_i/m_i/r_i/c_i/k_i  input chans, output chans, out rows, out cols, kernel
//                        size; captured when a start is accepted
//   busy_o               high while beats are being produced
//   done_o               one-cycle completion pulse
//   err_o                qualifies done_o: the captured config had a zero dim
//   beat_v_o             beat valid
//   beat_ready_i         consumer accepts the current beat
//   och_o .. kc_o        loop indices of the current beat
//   lane_mask_o          bit l set iff ch_base_o + l < n
//   first_o              first beat of an output pixel (accumulator init)
//   last_o               last beat of an output pixel (accumulator commit)
//
// Every output is a register or a decode of registers only; beat_ready_i
// reaches state, never an output directly.

module conv_tile_ctrl #(
  parameter int unsigned Tn_p    = 1,
  parameter int unsigned DIM_W_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic [DIM_W_p-1:0] n_i,
  input  logic [DIM_W_p-1:0] m_i,
  input  logic [DIM_W_p-1:0] r_i,
  input  logic [DIM_W_p-1:0] c_i,
  input  logic [DIM_W_p-1:0] k_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               beat_v_o,
  input  logic               beat_ready_i,
  output logic [DIM_W_p-1:0] och_o,
  output logic [DIM_W_p-1:0] row_o,
  output logic [DIM_W_p-1:0] col_o,
  output logic [DIM_W_p-1:0] ch_base_o,
  output logic [DIM_W_p-1:0] kr_o,
  output logic [DIM_W_p-1:0] kc_o,
  output logic [Tn_p-1:0]    lane_mask_o,
  output logic               first_o,
  output logic               last_o
);

  // Channel-group arithmetic uses one extra bit so ch_base + Tn_p cannot wrap
  // when n is close to 2^DIM_W_p.
  localparam int unsigned ExtW = DIM_W_p + 1;

  typedef logic [DIM_W_p-1:0] dim_t;
  typedef logic [ExtW-1:0]    ext_t;

  localparam dim_t DimOne = dim_t'(1);
  localparam ext_t TnExt  = ext_t'(Tn_p);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q;
  logic   err_q;

  // Captured tile configuration.
  dim_t n_q, m_q, r_q, c_q, k_q;

  // Loop counters; they are the beat payload.
  dim_t och_q, row_q, col_q, chb_q, kr_q, kc_q;

  logic run;
  logic cfg_zero;
  ext_t ch_next_ext;
  logic kc_wrap, kr_wrap, ch_wrap, col_wrap, row_wrap, och_wrap;
  logic final_beat;

  // Counter wrap decode and config check
  always_comb begin
    run         = (state_q == StRun);
    cfg_zero    = (n_i == '0) || (m_i == '0) || (r_i == '0) || (c_i == '0) || (k_i == '0);
    ch_next_ext = ext_t'(chb_q) + TnExt;

    kc_wrap  = (kc_q  == k_q - DimOne);
    kr_wrap  = (kr_q  == k_q - DimOne);
    ch_wrap  = (ch_next_ext >= ext_t'(n_q));
    col_wrap = (col_q == c_q - DimOne);
    row_wrap = (row_q == r_q - DimOne);
    och_wrap = (och_q == m_q - DimOne);

    final_beat = kc_wrap && kr_wrap && ch_wrap && col_wrap && row_wrap && och_wrap;
  end

  // Outputs: decoded from registered state only
  always_comb begin
    busy_o    = run;
    beat_v_o  = run;
    done_o    = (state_q == StDone);
    err_o     = (state_q == StDone) && err_q;
    och_o     = och_q;
    row_o     = row_q;
    col_o     = col_q;
    ch_base_o = chb_q;
    kr_o      = kr_q;
    kc_o      = kc_q;
    // Flags and mask are gated so they read 0 outside RUN (the index reset
    // values would otherwise decode as a first beat).
    first_o   = run && (chb_q == '0) && (kr_q == '0) && (kc_q == '0);
    last_o    = run && ch_wrap && kr_wrap && kc_wrap;
  end

  always_comb begin
    lane_mask_o = '0;
    for (int unsigned l = 0; l < Tn_p; l++) begin
      lane_mask_o[l] = run && ((ext_t'(chb_q) + ext_t'(l)) < ext_t'(n_q));
    end
  end

  // Controller FSM and odometer
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      n_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      och_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      chb_q   <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            n_q   <= n_i;
            m_q   <= m_i;
            r_q   <= r_i;
            c_q   <= c_i;
            k_q   <= k_i;
            och_q <= '0;
            row_q <= '0;
            col_q <= '0;
            chb_q <= '0;
            kr_q  <= '0;
            kc_q  <= '0;
            if (cfg_zero) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              err_q   <= 1'b0;
              state_q <= StRun;
            end
          end
        end

        StRun: begin
          if (beat_ready_i) begin
            // On the final beat every counter wraps, so indices land back on
            // zero for free as the FSM moves to DONE.
            if (final_beat) begin
              state_q <= StDone;
            end
            if (!kc_wrap) begin
              kc_q <= kc_q + DimOne;
            end else begin
              kc_q <= '0;
              if (!kr_wrap) begin
                kr_q <= kr_q + DimOne;
              end else begin
                kr_q <= '0;
                if (!ch_wrap) begin
                  chb_q <= ch_next_ext[DIM_W_p-1:0];
                end else begin
                  chb_q <= '0;
                  if (!col_wrap) begin
                    col_q <= col_q + DimOne;
                  end else begin
                    col_q <= '0;
                    if (!row_wrap) begin
                      row_q <= row_q + DimOne;
                    end else begin
                      row_q <= '0;
                      och_q <= och_wrap ? '0 : och_q + DimOne;
                    end
                  end
                end
              end
            end
          end
        end

        StDone: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
